// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared AHB transfer-type codes and arbiter state encoding
// for the AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        PARK,
        OWN,
        HANDOVER
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; scans req starting just after
// last and wrapping, so last itself is the lowest-priority candidate.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any_req
);

    logic [W-1:0] j;

    always_comb begin
        onehot  = '0;
        idx     = last;
        j       = '0;
        any_req = |req;
        // Walk from the farthest candidate to the nearest so the nearest requester wins.
        for (int i = N; i >= 1; i--) begin
            j = W'((int'(last) + i) % N);
            if (req[j]) idx = j;
        end
        if (any_req) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: round-robin arbiter for the bridge AHB slave port with tenure limit.
// Define HLOCK_EN to add the Hlock port and locked-tenure support.
module ahb_bridge_arbiter
    import ahb_apb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   Hclk,
    input  logic                   Hresetin,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
`ifdef HLOCK_EN
    input  logic [NUM_MASTERS-1:0] Hlock,
`endif
    input  logic [1:0]             Htrans,
    input  logic                   Hreadyout,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MW-1:0]          Hmaster,
    output logic                   Hmastlock
);

    localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t             state, state_d;
    logic [NUM_MASTERS-1:0] grant_d, win_oh;
    logic [MW-1:0]          gidx, gidx_d, master_d, win_idx;
    logic [HW-1:0]          hold, hold_d;
    logic                   lock_d, any_req, owner_req, other_req, lock_inh, rearb_ok;

    rr_pick #(.N(NUM_MASTERS), .W(MW)) u_pick (
        .req    (Hbusreq),
        .last   (Hmaster),
        .onehot (win_oh),
        .idx    (win_idx),
        .any_req(any_req)
    );

    always_comb begin
        owner_req = Hbusreq[Hmaster];
        other_req = |(Hbusreq & ~(NUM_MASTERS'(1) << Hmaster));
`ifdef HLOCK_EN
        lock_inh  = Hlock[Hmaster] && owner_req;
`else
        lock_inh  = 1'b0;
`endif
        rearb_ok  = Hreadyout && Htrans != HTRANS_SEQ && Htrans != HTRANS_BUSY && !lock_inh &&
                    (!owner_req || state == PARK ||
                     (MAX_HOLD != 0 && int'(hold) >= MAX_HOLD - 1 && other_req));
        state_d   = state;
        grant_d   = Hgrant;
        gidx_d    = gidx;
        master_d  = Hmaster;
        hold_d    = hold;
        case (state)
            PARK: begin
                hold_d = '0;
                if (any_req && rearb_ok) begin
                    grant_d = win_oh;
                    gidx_d  = win_idx;
                    state_d = win_idx != Hmaster ? HANDOVER : OWN;
                end
            end
            OWN: begin
                hold_d = int'(hold) < MAX_HOLD ? hold + 1'b1 : hold;
                if (rearb_ok && any_req && win_idx != Hmaster) begin
                    grant_d = win_oh;
                    gidx_d  = win_idx;
                    state_d = HANDOVER;
                end else if (!any_req) begin
                    state_d = PARK;
                end
            end
            default: begin
                master_d = gidx;
                hold_d   = '0;
                state_d  = Hbusreq[gidx] ? OWN : PARK;
            end
        endcase
`ifdef HLOCK_EN
        lock_d = Hlock[master_d];
`else
        lock_d = 1'b0;
`endif
    end

    always_ff @(posedge Hclk or posedge Hresetin) begin
        if (Hresetin) begin
            state     <= PARK;
            Hgrant    <= NUM_MASTERS'(1);
            gidx      <= '0;
            Hmaster   <= '0;
            Hmastlock <= 1'b0;
            hold      <= '0;
        end else if (Hreadyout) begin
            state     <= state_d;
            Hgrant    <= grant_d;
            gidx      <= gidx_d;
            Hmaster   <= master_d;
            Hmastlock <= lock_d;
            hold      <= hold_d;
        end
    end

endmodule
